// File: rtl/picomem_arb_pkg.sv
// ============================================================================
// Module   : picomem_arb_pkg
// Purpose  : Shared types and constants for the PicoMem 2:1 arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package picomem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } picomem_req_t;

    localparam logic [31:0] PICOMEM_ERR_RDATA = 32'hDEAD_BEEF;

    // One-hot owner vector; IDLE yields 2'b00.
    function automatic logic [1:0] state_to_grant(input arb_state_t st);
        logic [1:0] g;
        g = 2'b00;
        if (st == ST_GNT0) g = 2'b01;
        if (st == ST_GNT1) g = 2'b10;
        return g;
    endfunction

endpackage

`default_nettype wire

// File: rtl/picomem_arbiter_2_1.sv
// ============================================================================
// Module   : picomem_arbiter_2_1
// Purpose  : Two-master to one-slave PicoMem arbiter with per-access watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module picomem_arbiter_2_1
    import picomem_arb_pkg::*;
#(
    parameter int          ROUND_ROBIN   = 1,
    parameter int          TIMEOUT       = 1024,
    parameter logic [31:0] TIMEOUT_RDATA = PICOMEM_ERR_RDATA
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [WCNT_W-1:0] WCNT_SAT   = '1;
    localparam bit   WDOG_EN    = (TIMEOUT > 0);
    localparam bit   RR_EN      = (ROUND_ROBIN != 0);

    arb_state_t        state, state_nxt;
    logic              last, last_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;

    picomem_req_t req0, req1, act_req;
    logic         act_valid;
    logic         expire;
    logic         resp_ready;
    logic [31:0]  resp_rdata;

    assign req0 = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    assign req1 = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            last  <= 1'b1;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    assign grant = state_to_grant(state);

    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        wcnt_nxt    = wcnt;
        act_valid   = 1'b0;
        act_req     = '0;
        expire      = 1'b0;
        resp_ready  = 1'b0;
        resp_rdata  = '0;
        s_valid     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m0_rdata    = '0;
        m1_ready    = 1'b0;
        m1_rdata    = '0;
        timeout_err = 1'b0;

        case (state)
            ST_IDLE: begin
                wcnt_nxt = '0;
                if (m0_valid && m1_valid) begin
                    // Under round-robin the master that did not own the slave last wins.
                    if (RR_EN && !last) begin
                        state_nxt = ST_GNT1;
                        last_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_GNT0;
                        last_nxt  = 1'b0;
                    end
                end else if (m0_valid) begin
                    state_nxt = ST_GNT0;
                    last_nxt  = 1'b0;
                end else if (m1_valid) begin
                    state_nxt = ST_GNT1;
                    last_nxt  = 1'b1;
                end
            end

            ST_GNT0, ST_GNT1: begin
                act_valid = (state == ST_GNT0) ? m0_valid : m1_valid;
                act_req   = (state == ST_GNT0) ? req0 : req1;

                // A slave response in the expiry cycle takes precedence over the abort.
                expire = WDOG_EN && act_valid && !s_ready && (wcnt == WCNT_LIMIT);

                s_valid     = act_valid && !expire;
                s_addr      = act_req.addr;
                s_wdata     = act_req.wdata;
                s_wstrb     = act_req.wstrb;
                resp_ready  = s_ready || expire;
                resp_rdata  = expire ? TIMEOUT_RDATA : s_rdata;
                timeout_err = expire;

                if (s_ready || !act_valid || expire) begin
                    state_nxt = ST_IDLE;
                end else if (wcnt != WCNT_SAT) begin
                    wcnt_nxt = wcnt + WCNT_W'(1);
                end

                if (state == ST_GNT0) begin
                    m0_ready = resp_ready;
                    m0_rdata = resp_rdata;
                end else begin
                    m1_ready = resp_ready;
                    m1_rdata = resp_rdata;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
